sargantana_icache_array_arbiter: RTL
====================================

Name: sargantana_icache_array_arbiter

Overview:
Arbitration and sequencing controller for the I-cache tag/valid array port. It shares that single port between three requesters: queued L2 invalidations, an internal flush sweep FSM that walks every set, and core lookups. It sits between the I-cache control logic and the tag/valid memory. It issues one registered array command per cycle and reports flush progress to the control path.

Parameters:
N_SETS, 64, number of cache sets; must be a power of 2 and at least 2.
N_WAY, 4, number of ways.
IDX_W, $clog2(N_SETS), set index width (derived; do not override).
INV_DEPTH, 2, invalidation FIFO depth; must be a power of 2 and at least 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  flush request pulse
flush_done_o  out  1  one-cycle pulse when the sweep completes
busy_o  out  1  flush FSM not IDLE
inv_valid_i  in  1  L2 invalidation request
inv_idx_i  in  IDX_W  set index to invalidate
inv_way_i  in  $clog2(N_WAY)  way to invalidate
inv_ready_o  out  1  FIFO not full
lookup_valid_i  in  1  core lookup request
lookup_idx_i  in  IDX_W  lookup set index
lookup_ready_o  out  1  lookup granted this cycle
mem_req_o  out  1  array command valid
mem_we_o  out  1  write (invalidate) vs read
mem_idx_o  out  IDX_W  array set index
mem_way_mask_o  out  N_WAY  ways affected
mem_valid_bit_o  out  1  valid bit written; always 0 in this block

Behaviour:
- Single clock domain; synchronous active-high reset; all state updates on the rising edge of clk_i.
- Reset values:
  - FSM = IDLE, sweep counter = 0, FIFO empty.
  - mem_req_o = 0, mem_we_o = 0, mem_idx_o = 0, mem_way_mask_o = 0, mem_valid_bit_o = 0.
  - flush_done_o = 0, busy_o = 0, inv_ready_o = 1, lookup_ready_o = 0.
- Invalidation FIFO:
  - Push on inv_valid_i && inv_ready_o. inv_ready_o = !full, combinational from FIFO state only.
  - Push and pop in the same cycle are allowed whenever the FIFO is not full.
  - No bypass: a pushed entry is eligible for grant no earlier than the next cycle.
- Flush FSM:
  - IDLE -> SWEEP on flush_i; counter loads 0.
  - SWEEP: each cycle the sweep is granted, it issues a write to set = counter, all-ways mask, then increments the counter.
  - After the grant with counter = N_SETS-1, go to DONE. The counter wraps to 0.
  - DONE: flush_done_o = 1 for exactly one cycle, then return to IDLE.
  - flush_i in SWEEP restarts the sweep: counter = 0.
  - flush_i in DONE is ignored. The done pulse still fires.
  - busy_o = (state != IDLE).
- Fixed priority each cycle: FIFO head > sweep (state SWEEP) > core lookup.
  - Inv grant: pop the FIFO; write, idx = entry idx, mask = onehot(way).
  - Sweep grant: described under Flush FSM above.
  - Lookup grant: read, idx = lookup_idx_i, mask = all ones.
  - lookup_ready_o = lookup_valid_i && FIFO empty && state == IDLE. It is combinational.
  - Lookups are blocked for the whole sweep, including DONE.
  - The sweep counter holds on any cycle the FIFO wins.
- Latency: the command granted in cycle t appears on mem_* in cycle t+1. All mem_* outputs are registered.
  - No grant in cycle t: mem_req_o = 0 in t+1. mem_idx_o and mem_way_mask_o hold their previous values.
- flush_i and inv_valid_i in the same cycle: both are accepted. The invalidation issues first. Redundant invalidations are harmless.
- Reset mid-sweep aborts the sweep: FSM goes to IDLE, the FIFO contents are discarded, and no flush_done_o pulse is produced.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs at their reset values; inv_ready_o = 1.
- lookup_valid_i = 1, lookup_idx_i = 5 in cycle t -> lookup_ready_o = 1 in t; in t+1: mem_req_o = 1, mem_we_o = 0, mem_idx_o = 5, mask = 4'b1111.
- N_SETS = 8, flush_i pulse in cycle t, no other traffic -> writes to idx 0..7 on mem_* in cycles t+2..t+9, all with mask 4'b1111; flush_done_o = 1 only in cycle t+9; busy_o = 1 in cycles t+1..t+9; lookups stalled throughout.
- Invalidation pushed (idx 3, way 2) at sweep counter 4 -> the FIFO entry issues ahead of the sweep (mem_idx_o = 3, mask = 4'b0100); the sweep resumes at idx 4 with no set skipped; flush_done_o is delayed by exactly 1 cycle.
- Hold lookup_valid_i = 1 and push 3 invalidations back-to-back, INV_DEPTH = 2 -> inv_ready_o drops to 0 only after two entries are queued with no pop; all 3 invalidations issue before lookup_ready_o rises.
- Assert rst_i at sweep counter 3 with 1 FIFO entry queued -> next cycle: FSM IDLE, FIFO empty, busy_o = 0, mem_req_o = 0, and no flush_done_o pulse.

Source files
------------

// File: rtl/sargantana_icache_array_arbiter.sv
// I-cache tag/valid array port arbiter.
// Shares the port between L2 invalidations, a flush sweep and core lookups.
module sargantana_icache_array_arbiter #(
    parameter int N_SETS    = 64,
    parameter int N_WAY     = 4,
    parameter int INV_DEPTH = 2,
    localparam int IDX_W    = $clog2(N_SETS),
    localparam int WAY_W    = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    output logic             flush_done_o,
    output logic             busy_o,
    input  logic             inv_valid_i,
    input  logic [IDX_W-1:0] inv_idx_i,
    input  logic [WAY_W-1:0] inv_way_i,
    output logic             inv_ready_o,
    input  logic             lookup_valid_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_ready_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [IDX_W-1:0] mem_idx_o,
    output logic [N_WAY-1:0] mem_way_mask_o,
    output logic             mem_valid_bit_o
);

    localparam int PTR_W = $clog2(INV_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ctr_q, ctr_d;

    logic [IDX_W-1:0] fifo_idx_q [INV_DEPTH];
    logic [WAY_W-1:0] fifo_way_q [INV_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;

    logic             fifo_full, fifo_empty, push, pop;

    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_WAY-1:0] mask_q, mask_d;

    logic             grant_inv, grant_swp, grant_lk;

    assign fifo_full  = (cnt_q == (PTR_W+1)'(INV_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign push       = inv_valid_i && !fifo_full;
    assign pop        = grant_inv;

    assign inv_ready_o    = !fifo_full;
    assign busy_o         = (state_q != IDLE);
    assign flush_done_o   = (state_q == DONE);
    assign lookup_ready_o = lookup_valid_i && fifo_empty
                            && (state_q == IDLE);

    assign grant_inv = !fifo_empty;
    assign grant_swp = fifo_empty && (state_q == SWEEP);
    assign grant_lk  = lookup_ready_o;

    assign mem_req_o       = req_q;
    assign mem_we_o        = we_q;
    assign mem_idx_o       = idx_q;
    assign mem_way_mask_o  = mask_q;
    assign mem_valid_bit_o = 1'b0;

    // Flush FSM next state and sweep counter; a new flush restarts the walk.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = SWEEP;
                    ctr_d   = '0;
                end
            end
            SWEEP: begin
                if (grant_swp) begin
                    ctr_d = ctr_q + IDX_W'(1);
                    if (ctr_q == IDX_W'(N_SETS - 1)) begin
                        state_d = DONE;
                    end
                end
                if (flush_i) begin
                    state_d = SWEEP;
                    ctr_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    // Array command for next cycle; index and mask hold when idle.
    always_comb begin
        req_d  = 1'b0;
        we_d   = 1'b0;
        idx_d  = idx_q;
        mask_d = mask_q;
        if (grant_inv) begin
            req_d  = 1'b1;
            we_d   = 1'b1;
            idx_d  = fifo_idx_q[rd_ptr_q];
            mask_d = N_WAY'(1) << fifo_way_q[rd_ptr_q];
        end else if (grant_swp) begin
            req_d  = 1'b1;
            we_d   = 1'b1;
            idx_d  = ctr_q;
            mask_d = '1;
        end else if (grant_lk) begin
            req_d  = 1'b1;
            we_d   = 1'b0;
            idx_d  = lookup_idx_i;
            mask_d = '1;
        end
    end

    // Control state, FIFO pointers and registered array command.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ctr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - (PTR_W+1)'(1);
            end
        end
    end

    // FIFO payload storage; validity is tracked by the pointers only.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q] <= inv_idx_i;
            fifo_way_q[wr_ptr_q] <= inv_way_i;
        end
    end

endmodule
